// File: rtl/interrupt_scheduler_pkg.sv
// Shared register map, FSM encodings and winner selection for interrupt_scheduler.
// Latency: combinational helpers only.
// Backpressure: none; pure definitions.
package interrupt_scheduler_pkg;

    localparam int unsigned MAX_SRC = 8;
    localparam int          ID_W    = 3;

    // Register addresses on the port bus
    localparam logic [1:0] ADDR_ENABLE = 2'd0;
    localparam logic [1:0] ADDR_EDGE   = 2'd1;
    localparam logic [1:0] ADDR_PEND   = 2'd2;
    localparam logic [1:0] ADDR_STAT   = 2'd3;

    // FSM encodings kept as plain constants so software-visible debug taps stay stable
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ASSERT  = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    localparam int IN_SERVICE_BIT = 7;

    // First set bit of req scanning upward from start, wrapping at num_src.
    // With start fixed at 0 this is plain fixed priority, index 0 highest.
    function automatic logic [ID_W-1:0] pick_winner(
        input logic [MAX_SRC-1:0] req,
        input logic [ID_W-1:0]    start,
        input int unsigned        num_src
    );
        logic [ID_W-1:0] win;
        logic [ID_W-1:0] idx;
        logic            found;
        win   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_SRC; i++) begin
            idx = ID_W'((32'(start) + i) % num_src);
            if (!found && (i < num_src) && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/interrupt_scheduler_irq_capture.sv
// Per-source 2-flop synchroniser with rising-edge or level-high event output.
// Latency: event visible 2 edges after the source is first sampled.
// Backpressure: none; events are level outputs consumed by the pending register.
module irq_capture (
    input  logic clk,
    input  logic rst,
    input  logic src,
    input  logic edge_sel,
    output logic evt
);

    logic s1;
    logic s2;
    logic prev;

    // Synchronise the raw source and keep one cycle of history for edge detect
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= src;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign evt = edge_sel ? (s2 & ~prev) : s2;

endmodule

// File: rtl/interrupt_scheduler.sv
// Captures up to 8 interrupt sources, arbitrates one and drives the PicoBlaze interrupt with ack/EOI tracking.
// Latency: source edge sampled at edge k -> pending at k+2 -> cpu_int high after k+3; EOI to next cpu_int is 1 edge.
// Backpressure: one interrupt in service at a time; further requests stay pending until EOI. Build option ROUND_ROBIN_EN.
module interrupt_scheduler
    import interrupt_scheduler_pkg::*;
#(
    parameter int NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [1:0]         reg_addr,
    input  logic               reg_we,
    input  logic [7:0]         reg_wdata,
    output logic [7:0]         reg_rdata,
    output logic               cpu_int,
    input  logic               cpu_int_ack
);

    localparam logic [8:0]         SRC_LIMIT = 9'd1 << NUM_SRC;
    localparam logic [MAX_SRC-1:0] SRC_MASK  = 8'(SRC_LIMIT - 9'd1);

    logic [MAX_SRC-1:0] enable_q;
    logic [MAX_SRC-1:0] edge_q;
    logic [MAX_SRC-1:0] pend_q;
    logic [MAX_SRC-1:0] pend_d;
    logic [MAX_SRC-1:0] clr_vec;
    logic [MAX_SRC-1:0] evt_vec;
    logic [MAX_SRC-1:0] req_vec;
    logic [1:0]         state_q;
    logic [1:0]         state_d;
    logic [ID_W-1:0]    active_id;
    logic [ID_W-1:0]    winner;
    logic [ID_W-1:0]    rr_start;
    logic               in_service;
    logic               wr_pend;
    logic               eoi;
    logic               ack_hit;

    for (genvar g = 0; g < MAX_SRC; g++) begin : g_src
        if (g < NUM_SRC) begin : g_used
            irq_capture u_cap (
                .clk      (clk),
                .rst      (rst),
                .src      (irq_src[g]),
                .edge_sel (edge_q[g]),
                .evt      (evt_vec[g])
            );
        end else begin : g_unused
            assign evt_vec[g] = 1'b0;
        end
    end

    assign wr_pend = reg_we && (reg_addr == ADDR_PEND);
    assign eoi     = reg_we && (reg_addr == ADDR_STAT);
    assign ack_hit = (state_q == ST_ASSERT) && cpu_int_ack;
    assign req_vec = pend_q & enable_q;

    // Clear sources: software W1C and auto-clear of an acknowledged edge-type source
    always_comb begin
        clr_vec = '0;
        if (wr_pend) begin
            clr_vec = reg_wdata;
        end
        if (ack_hit && edge_q[active_id]) begin
            clr_vec[active_id] = 1'b1;
        end
    end

    // New events override clears so a still-high level source re-pends immediately
    assign pend_d = ((pend_q & ~clr_vec) | evt_vec) & SRC_MASK;

`ifdef ROUND_ROBIN_EN
    logic [ID_W-1:0] last_served;

    // Remember the most recently acknowledged source; reset value makes index 0 win first
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_served <= ID_W'(NUM_SRC - 1);
        end else if (ack_hit) begin
            last_served <= active_id;
        end
    end

    assign rr_start = last_served + 1'b1;
`else
    assign rr_start = '0;
`endif

    assign winner = pick_winner(req_vec, rr_start, NUM_SRC);

    // Control registers and the pending register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enable_q <= '0;
            edge_q   <= '0;
            pend_q   <= '0;
        end else begin
            if (reg_we && (reg_addr == ADDR_ENABLE)) begin
                enable_q <= reg_wdata & SRC_MASK;
            end
            if (reg_we && (reg_addr == ADDR_EDGE)) begin
                edge_q <= reg_wdata & SRC_MASK;
            end
            pend_q <= pend_d;
        end
    end

    // Next state: raise on any request, drop if the winner is withdrawn, hold through service until EOI
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_vec) begin
                    state_d = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (cpu_int_ack) begin
                    state_d = ST_SERVICE;
                end else if (!req_vec[active_id]) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (eoi) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, registered cpu_int, winner latch and in-service flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cpu_int    <= 1'b0;
            active_id  <= '0;
            in_service <= 1'b0;
        end else begin
            state_q <= state_d;
            cpu_int <= (state_d == ST_ASSERT);
            if ((state_q == ST_IDLE) && (|req_vec)) begin
                active_id <= winner;
            end
            if (ack_hit) begin
                in_service <= 1'b1;
            end else if ((state_q == ST_SERVICE) && eoi) begin
                in_service <= 1'b0;
            end
        end
    end

    // Read mux, combinational from the address
    always_comb begin
        reg_rdata = '0;
        case (reg_addr)
            ADDR_ENABLE: reg_rdata = enable_q;
            ADDR_EDGE:   reg_rdata = edge_q;
            ADDR_PEND:   reg_rdata = pend_q;
            ADDR_STAT: begin
                reg_rdata[IN_SERVICE_BIT] = in_service;
                reg_rdata[ID_W-1:0]       = active_id;
            end
            default: reg_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_interrupt_scheduler.sv
// Directed self-checking bench for interrupt_scheduler.
// Latency: checks sampled on the falling clock edge, half a cycle after each active edge.
// Backpressure: not applicable; stimulus is a fixed directed sequence.
module tb_interrupt_scheduler;

    logic       clk;
    logic       rst;
    logic [7:0] irq_src;
    logic [1:0] reg_addr;
    logic       reg_we;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;
    logic       cpu_int;
    logic       cpu_int_ack;

    int n_checks;
    int n_fail;

`ifdef ROUND_ROBIN_EN
    localparam logic [7:0] RR_FIRST  = 8'h05;
    localparam logic [7:0] RR_SECOND = 8'h02;
`else
    localparam logic [7:0] RR_FIRST  = 8'h02;
    localparam logic [7:0] RR_SECOND = 8'h05;
`endif

    interrupt_scheduler #(.NUM_SRC(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .irq_src     (irq_src),
        .reg_addr    (reg_addr),
        .reg_we      (reg_we),
        .reg_wdata   (reg_wdata),
        .reg_rdata   (reg_rdata),
        .cpu_int     (cpu_int),
        .cpu_int_ack (cpu_int_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input logic exp);
        check(tag, {7'b0, cpu_int}, {7'b0, exp});
    endtask

    task automatic check_reg(input string tag, input logic [1:0] a, input logic [7:0] exp);
        reg_addr = a;
        #1;
        check(tag, reg_rdata, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
        reg_addr  = a;
        reg_wdata = d;
        reg_we    = 1'b1;
        @(negedge clk);
        reg_we    = 1'b0;
    endtask

    task automatic pulse_ack();
        cpu_int_ack = 1'b1;
        @(negedge clk);
        cpu_int_ack = 1'b0;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        irq_src     = 8'h00;
        reg_addr    = 2'd0;
        reg_we      = 1'b0;
        reg_wdata   = 8'h00;
        cpu_int_ack = 1'b0;

        // Reset state
        #2 rst = 1'b0;
        #1;
        check_int("rst_cpu_int", 1'b0);
        check_reg("rst_enable", 2'd0, 8'h00);
        check_reg("rst_pending", 2'd2, 8'h00);
        check_reg("rst_status", 2'd3, 8'h00);
        tick(2);
        rst = 1'b1;
        tick(1);

        // Basic edge flow on source 0
        write_reg(2'd0, 8'h01);
        write_reg(2'd1, 8'h01);
        irq_src = 8'h01;
        tick(3);
        check_int("edge_lat_k2", 1'b0);
        check_reg("edge_pend_set", 2'd2, 8'h01);
        tick(1);
        check_int("edge_lat_k3", 1'b1);
        check_reg("edge_stat_assert", 2'd3, 8'h00);
        irq_src = 8'h00;
        pulse_ack();
        check_int("edge_ack_int", 1'b0);
        check_reg("edge_ack_stat", 2'd3, 8'h80);
        check_reg("edge_ack_pend", 2'd2, 8'h00);
        write_reg(2'd3, 8'h00);
        check_reg("edge_eoi_stat", 2'd3, 8'h00);
        tick(3);
        check_int("edge_quiet", 1'b0);

        // Fixed priority: sources 2 and 5 together
        write_reg(2'd0, 8'hFF);
        write_reg(2'd1, 8'hFF);
        irq_src = 8'h24;
        tick(4);
        check_int("prio_int", 1'b1);
        check_reg("prio_first_id", 2'd3, 8'h02);
        irq_src = 8'h00;
        pulse_ack();
        check_reg("prio_ack_stat", 2'd3, 8'h82);
        check_reg("prio_ack_pend", 2'd2, 8'h20);
        write_reg(2'd3, 8'h00);
        check_int("prio_eoi_low", 1'b0);
        tick(1);
        check_int("prio_b2b_int", 1'b1);
        check_reg("prio_second_id", 2'd3, 8'h05);
        pulse_ack();
        write_reg(2'd3, 8'h00);
        tick(1);

        // Source 2 served, then 2 and 5 arrive together during service
        irq_src = 8'h04;
        tick(4);
        check_int("rr_pre_int", 1'b1);
        irq_src = 8'h00;
        pulse_ack();
        check_reg("rr_pre_stat", 2'd3, 8'h82);
        irq_src = 8'h24;
        tick(2);
        irq_src = 8'h00;
        tick(3);
        check_int("rr_held_int", 1'b0);
        check_reg("rr_held_pend", 2'd2, 8'h24);
        write_reg(2'd3, 8'h00);
        tick(1);
        check_int("rr_first_int", 1'b1);
        check_reg("rr_first_id", 2'd3, RR_FIRST);
        pulse_ack();
        write_reg(2'd3, 8'h00);
        tick(1);
        check_int("rr_second_int", 1'b1);
        check_reg("rr_second_id", 2'd3, RR_SECOND);
        pulse_ack();
        write_reg(2'd3, 8'h00);
        tick(1);
        check_reg("rr_drained", 2'd2, 8'h00);

        // Level re-pend on source 3
        write_reg(2'd1, 8'h00);
        irq_src = 8'h08;
        tick(4);
        check_int("lvl_int", 1'b1);
        check_reg("lvl_id", 2'd3, 8'h03);
        pulse_ack();
        check_reg("lvl_ack_stat", 2'd3, 8'h83);
        check_reg("lvl_ack_pend", 2'd2, 8'h08);
        write_reg(2'd3, 8'h00);
        check_reg("lvl_eoi_pend", 2'd2, 8'h08);
        tick(1);
        check_int("lvl_reassert", 1'b1);
        irq_src = 8'h00;
        tick(3);
        write_reg(2'd2, 8'h08);
        check_reg("lvl_w1c_pend", 2'd2, 8'h00);
        tick(1);
        check_int("lvl_drop_int", 1'b0);
        tick(3);
        check_int("lvl_stays_low", 1'b0);

        // Mask during ASSERT on source 1
        write_reg(2'd1, 8'hFF);
        irq_src = 8'h02;
        tick(4);
        check_int("mask_int", 1'b1);
        irq_src = 8'h00;
        write_reg(2'd0, 8'h00);
        tick(1);
        check_int("mask_int_low", 1'b0);
        check_reg("mask_stat_idle", 2'd3, 8'h01);
        check_reg("mask_pend_kept", 2'd2, 8'h02);
        write_reg(2'd0, 8'hFF);
        tick(1);
        check_int("mask_reenable", 1'b1);
        check_reg("mask_reenable_id", 2'd3, 8'h01);
        pulse_ack();
        check_reg("mask_ack_pend", 2'd2, 8'h00);
        write_reg(2'd3, 8'h00);
        tick(1);

        // Hold-off during service and stray strobes
        irq_src = 8'h10;
        tick(4);
        check_int("hold_int", 1'b1);
        irq_src = 8'h00;
        pulse_ack();
        check_reg("hold_svc_stat", 2'd3, 8'h84);
        irq_src = 8'h40;
        tick(2);
        irq_src = 8'h00;
        tick(3);
        check_int("hold_no_int", 1'b0);
        check_reg("hold_pend", 2'd2, 8'h40);
        pulse_ack();
        check_reg("hold_stray_ack", 2'd3, 8'h84);
        check_int("hold_stray_int", 1'b0);
        write_reg(2'd3, 8'h00);
        tick(1);
        check_int("hold_next_int", 1'b1);
        check_reg("hold_next_id", 2'd3, 8'h06);
        pulse_ack();
        write_reg(2'd3, 8'h00);
        tick(2);
        pulse_ack();
        check_reg("idle_ack_stat", 2'd3, 8'h06);
        check_int("idle_ack_int", 1'b0);
        write_reg(2'd3, 8'h00);
        check_reg("idle_eoi_stat", 2'd3, 8'h06);
        check_reg("idle_eoi_pend", 2'd2, 8'h00);
        tick(1);
        check_int("idle_eoi_int", 1'b0);

        // Asynchronous reset in the middle of ASSERT
        irq_src = 8'h01;
        tick(4);
        check_int("arst_pre_int", 1'b1);
        #2 rst = 1'b0;
        #1;
        check_int("arst_int_now", 1'b0);
        irq_src = 8'h00;
        @(negedge clk);
        rst = 1'b1;
        check_reg("arst_enable", 2'd0, 8'h00);
        check_reg("arst_pending", 2'd2, 8'h00);
        check_reg("arst_status", 2'd3, 8'h00);
        tick(5);
        check_int("arst_quiet", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/interrupt_scheduler.md
Name: interrupt_scheduler

Overview:
- Collects up to 8 raw interrupt sources, synchronises and captures each as edge- or level-type, and holds them in a pending register.
- Selects one winner by priority and drives the single PicoBlaze interrupt input.
- Tracks the CPU acknowledge and end-of-interrupt (EOI) sequence so only one interrupt is in service at a time.
- Registers are accessed through the PicoBlaze port bus (port_id/write_strobe/in_port decode lives outside).

Parameters:
- NUM_SRC, 8, number of interrupt sources (1..8); unused register bits read 0 and ignore writes.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low (asserted when 0)
- irq_src  in  NUM_SRC  raw asynchronous interrupt sources
- reg_addr  in  2  register select
- reg_we  in  1  write strobe, one cycle
- reg_wdata  in  8  write data
- reg_rdata  out  8  read data, combinational from reg_addr
- cpu_int  out  1  interrupt request to CPU
- cpu_int_ack  in  1  CPU interrupt acknowledge pulse

Behaviour:
- Register map:
  - 0 ENABLE: RW mask, reset 0x00.
  - 1 EDGE_SEL: RW, 1 = rising-edge source, 0 = level-high source; reset 0x00.
  - 2 PENDING: read returns pending; write-1-to-clear.
  - 3 STATUS: read {in_service, 4'b0, active_id[2:0]}; any write = EOI.
- Capture, per source:
  - 2-flop synchroniser (s1, s2), then prev <= s2; all reset to 0.
  - Edge event = s2 & ~prev.
  - Level event = s2.
  - The pending bit sets on its event regardless of ENABLE.
- Pending clear paths: W1C write, or auto-clear of active_id on cpu_int_ack when that source is edge-type. Set wins over a clear in the same cycle, so a level source still high re-pends at once.
- Request = pending & ENABLE.
- Priority: index 0 is highest (fixed).
- FSM, encoded IDLE=0, ASSERT=1, SERVICE=2:
  - IDLE: if request != 0, latch winner into active_id and go to ASSERT.
  - ASSERT: cpu_int = 1. On cpu_int_ack, go to SERVICE and set in_service = 1. If request[active_id] drops (masked or W1C), go to IDLE with cpu_int = 0.
  - SERVICE: cpu_int = 0. Other requests are held. On an EOI write, go to IDLE and clear in_service.
- cpu_int is a registered output, high exactly in ASSERT.
- Latency: a source edge sampled at clk edge k sets pending at edge k+2, and cpu_int rises after edge k+3 (4 edges total).
- A request present in IDLE is re-arbitrated every IDLE cycle. Back-to-back: EOI at edge n, next cpu_int high after edge n+1.
- cpu_int_ack in IDLE or SERVICE is ignored.
- EOI write in IDLE or ASSERT is ignored.
- ENABLE change during SERVICE has no effect until IDLE.
- Reset mid-operation: all flops return to reset values immediately. Outputs reset to cpu_int = 0 and reg_rdata = 0x00; ENABLE = 0 forces reg_rdata = 0 at addr 0.

Optional Feature:
- ROUND_ROBIN_EN
  - Defined: arbitration starts at (last_served + 1) mod NUM_SRC and wraps. last_served updates on cpu_int_ack and resets to NUM_SRC-1, so index 0 wins first after reset.
  - Undefined: fixed priority, index 0 highest, and no last_served register.

Decomposition:
- Shared package interrupt_scheduler_pkg holds:
  - register addresses: ADDR_ENABLE=0, ADDR_EDGE=1, ADDR_PEND=2, ADDR_STAT=3
  - FSM state encodings
  - ID_W=3
  - STATUS bit position IN_SERVICE_BIT=7
- One sub-module: irq_capture (synchroniser + edge/level event generation), instantiated NUM_SRC times.
- Priority/round-robin selection is a function in the package.

Test Plan:
- Basic edge flow: ENABLE=0x01, EDGE=0x01, pulse irq_src[0] → cpu_int high 4 edges later; ack → cpu_int 0, STATUS=0x80, PENDING=0x00; EOI → STATUS=0x00.
- Priority: irq_src[5] and [2] rise together, ENABLE=0xFF, EDGE=0xFF → active_id=2. After EOI, the second cpu_int gives active_id=5. With ROUND_ROBIN_EN and last_served=2, sources 2 and 5 together → 5 wins.
- Level re-pend: EDGE=0x00, irq_src[3] held high; ack then EOI → PENDING bit 3 stays 1 and cpu_int reasserts. Drop irq_src[3] and W1C 0x08 → PENDING=0x00, cpu_int stays 0.
- Mask during ASSERT: source 1 pending, cpu_int high; write ENABLE=0x00 → cpu_int low the next cycle, FSM in IDLE, PENDING bit 1 still 1. Re-enable → cpu_int returns.
- Hold-off and stray strobes: a second source arrives during SERVICE → no cpu_int until EOI. A cpu_int_ack pulse in IDLE and an EOI in IDLE cause no state change.
- Async reset: assert rst=0 mid-ASSERT without a clock edge → cpu_int=0 immediately; ENABLE, PENDING and STATUS read 0x00 after release.
